// File: rtl/iir_out_buffer_if.sv
// iir_out_buffer_if: producer/consumer bundle around the IIR output buffer.
// slave is the buffer side, master is the environment driving samples and ready.
interface iir_out_buffer_if #(
    parameter int NB    = 12,
    parameter int DEPTH = 8
);
    logic                       vIn;
    logic [NB:0]                dIn;
    logic                       rdy;
    logic                       clr_ovf;
    logic                       vOut;
    logic [NB:0]                dOut;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH):0]     count;
    logic                       ovf;

    modport slave  (input  vIn, dIn, rdy, clr_ovf,
                    output vOut, dOut, full, empty, count, ovf);
    modport master (output vIn, dIn, rdy, clr_ovf,
                    input  vOut, dOut, full, empty, count, ovf);
endinterface

// File: rtl/iir_out_buffer.sv
// iir_out_buffer: elastic FIFO after iir_filter; absorbs consumer back-pressure,
// drops samples when full and flags them on a sticky overflow bit.
module iir_out_buffer #(
    parameter int NB    = 12,
    parameter int DEPTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    iir_out_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [NB:0]   mem [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full, empty, push, pop, drop;

    // A full buffer still accepts when the head leaves in the same cycle.
    always_comb begin
        full    = count_q == (AW+1)'(DEPTH);
        empty   = count_q == '0;
        pop     = !empty && bus.rdy;
        push    = bus.vIn && (!full || pop);
        drop    = bus.vIn && full && !bus.rdy;
        wp_d    = push ? wp_q + 1'b1 : wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d   = drop || (ovf_q && !bus.clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= bus.dIn;
    end

    assign bus.vOut  = !empty;
    assign bus.dOut  = empty ? '0 : mem[rp_q];
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: doc/iir_out_buffer.md
# iir_out_buffer

Elastic output stage placed directly downstream of `iir_filter`: captures every filtered sample flagged by the filter's `vOut` and presents it to the consumer (`data_sink` or the next processing stage) over a valid/ready handshake. Absorbs consumer back-pressure, which `iir_filter` cannot honour because it has no stall input. Samples arriving with the buffer full are dropped and reported through a sticky overflow flag.

## Interface

- `NB`, 12, data width is NB+1 bits (two's complement, matches `iir_filter` dOut)
- `DEPTH`, 8, number of sample slots; power of two, 2..64
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `vIn`  in  1  sample valid from `iir_filter` vOut
- `dIn`  in  NB+1  sample from `iir_filter` dOut
- `rdy`  in  1  consumer ready
- `clr_ovf`  in  1  synchronous clear of `ovf`
- `vOut`  out  1  head sample valid
- `dOut`  out  NB+1  head sample
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `count`  out  log2(DEPTH)+1  occupancy
- `ovf`  out  1  sticky: at least one sample dropped

## Operation

- Circular buffer: DEPTH-entry storage, write pointer `wp`, read pointer `rp`, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0. Occupancy counter `count` is held explicitly; full/empty derive from `count`, not from pointer comparison.
- Push: `vIn`=1 and (`full`=0 or pop in same cycle). Stores `dIn` at `wp`, increments `wp`.
- Pop: `vOut`=1 and `rdy`=1. Increments `rp`.
- `count` next = count + push - pop; push and pop together leave it unchanged.
- Drop: `vIn`=1, `full`=1, `rdy`=0. Sample discarded, pointers unchanged, `ovf` set next edge.
- Full with `vIn`=1 and `rdy`=1: pop and push both happen, no drop, `count` stays DEPTH.
- Empty with `vIn`=1 and `rdy`=1: push only. No bypass; the new sample is not popped in its arrival cycle.
- `vOut` = not `empty`. `dOut` = storage[`rp`] when `vOut`=1, else all zeros. `dOut` is never X after reset.
- `ovf`: set on drop, cleared by `clr_ovf`=1. If both occur in the same cycle, set wins.
- Data is passed bit-exact: no rounding, saturation or sign change.
- `dIn` is ignored whenever `vIn`=0.
- Reset (any time, including mid-transfer): `wp`=`rp`=0, `count`=0, `ovf`=0. Consequently `vOut`=0, `dOut`=0, `empty`=1, `full`=0. Storage contents are not reset and are unobservable while empty.

## Timing

- Single clock domain. All state updates on the rising `clk` edge. `rst_n` acts immediately on assertion; deassertion is synchronous to `clk` by the driver.
- Latency: a sample pushed at edge k appears on `vOut`/`dOut` in cycle k+1, when the buffer was empty.
- `full`, `empty`, `count` and `ovf` reflect the state after the last edge. All are registered-state decodes, with no combinational path from `vIn`.
- `rdy` to push-accept is a combinational path, used for the full+pop case only. `vOut` does not depend on `rdy`.
- Throughput: one push and one pop per cycle sustained.
- The producer may assert `vIn` every cycle. The consumer may toggle `rdy` arbitrarily. `vOut`/`dOut` are held stable until popped.

## Test plan

- Reset/idle: assert `rst_n`=0 mid-run with `count`=5. Required: `vOut`=0, `dOut`=0, `empty`=1, `count`=0, `ovf`=0 immediately. After release with `vIn`=0, all stay constant.
- Pass-through: `rdy`=1 constantly, push 0x001, 0x7FF, 0x1000, 0x0FFF on consecutive cycles. Required: the same four values on `dOut` with `vOut`=1, one cycle after each push, in order. `count` never exceeds 1.
- Fill and overflow: `rdy`=0, push 10 samples 1..10 with DEPTH=8. Required: `full`=1 after the 8th push; samples 9 and 10 dropped; `ovf`=1 from the cycle after sample 9. Then raise `rdy`: outputs are 1..8 only, after which `empty`=1.
- Full with simultaneous push/pop: at `full`=1, `vIn`=1 with 0x0AA and `rdy`=1 for one cycle. Required: no drop, `ovf` unchanged, `count`=8, and 0x0AA emerges as the 8th sample after the current head.
- Pointer wrap under random back-pressure: 1000 samples with `vIn` 70% and `rdy` 50% random, kept below overflow. Required: output sequence equals input sequence, `count` matches a reference model every cycle, and `ovf` stays 0.
- `ovf` clear race: drop and `clr_ovf`=1 in the same cycle, then `clr_ovf`=1 alone in the following cycle. Required: `ovf`=1 after the first edge and 0 after the second.
